// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - registered N-source bus multiplexer with conflict detection
// Optional RR_ARB_EN selects round-robin winners on multi-driver cycles (default: lowest index).
module bus_arbiter_mux #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 24,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_out,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        bus_sel,
  output logic                    conflict,
  output logic                    conflict_sticky,
  output logic [7:0]              conflict_cnt
);

  localparam logic [N_SRC-1:0] src_one = N_SRC'(1);

  logic [DATA_W-1:0] words [N_SRC];
  logic              none_req;
  logic              multi_req;
  logic [SEL_W-1:0]  win;
  logic [7:0]        cnt_base;
  logic [7:0]        cnt_next;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign words[g] = src_data[g*DATA_W +: DATA_W];
  end

  // Clearing the lowest set bit leaves something only when two or more strobes are set.
  assign none_req  = ~|src_out;
  assign multi_req = |(src_out & (src_out - src_one));

`ifdef RR_ARB_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W:0]   idx;
  logic             found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N_SRC)) idx = idx - (SEL_W+1)'(N_SRC);
      if (!found && src_out[idx[SEL_W-1:0]]) begin
        win   = idx[SEL_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_ptr <= '0;
    end else if (multi_req) begin
      rr_ptr <= (win == SEL_W'(N_SRC-1)) ? '0 : win + SEL_W'(1);
    end
  end
`else
  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    win = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (src_out[i]) win = SEL_W'(i);
    end
  end
`endif

  // A conflict on the same cycle as err_clr counts as the first event after the clear.
  always_comb begin
    cnt_base = err_clr ? 8'd0 : conflict_cnt;
    cnt_next = cnt_base;
    if (multi_req && cnt_base != 8'hff) cnt_next = cnt_base + 8'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_out         <= '0;
      bus_sel         <= '0;
      bus_valid       <= 1'b0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= 8'd0;
    end else begin
      if (!none_req) begin
        bus_out <= words[win];
        bus_sel <= win;
      end
      bus_valid       <= !none_req;
      conflict        <= multi_req;
      conflict_sticky <= multi_req | (conflict_sticky & ~err_clr);
      conflict_cnt    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - scoreboard bench for bus_arbiter_mux
module tb_bus_arbiter_mux;

  localparam int DW = 32;
  localparam int NS = 24;
  localparam int SW = 5;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]  src_out = '0;
  logic           err_clr = 1'b0;
  logic [DW-1:0]  bus_out;
  logic           bus_valid;
  logic [SW-1:0]  bus_sel;
  logic           conflict;
  logic           conflict_sticky;
  logic [7:0]     conflict_cnt;

  bus_arbiter_mux #(.DATA_W(DW), .N_SRC(NS), .SEL_W(SW)) dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_sel(bus_sel), .conflict(conflict),
    .conflict_sticky(conflict_sticky), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          valid;
    logic          conf;
    logic          sticky;
    logic [7:0]    cnt;
  } exp_t;

  exp_t          sb [$];
  exp_t          m;
  int            rr;
  logic [DW-1:0] words [NS];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m  = '0;
    rr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".bus_out"},  64'(bus_out), 64'd0);
    check_eq({tag, ".valid"},    64'(bus_valid), 64'd0);
    check_eq({tag, ".sel"},      64'(bus_sel), 64'd0);
    check_eq({tag, ".conflict"}, 64'(conflict), 64'd0);
    check_eq({tag, ".sticky"},   64'(conflict_sticky), 64'd0);
    check_eq({tag, ".cnt"},      64'(conflict_cnt), 64'd0);
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
  task automatic step(input logic [NS-1:0] so, input logic ec, input int fi, input logic [DW-1:0] fw);
    exp_t e;
    int   n;
    int   w;
    int   idx;
    for (int i = 0; i < NS; i++) begin
      words[i] = $urandom;
      if (i == fi) words[i] = fw;
      src_data[i*DW +: DW] = words[i];
    end
    src_out = so;
    err_clr = ec;
    n = 0;
    w = -1;
    for (int i = 0; i < NS; i++) if (so[i]) n++;
    for (int k = 0; k < NS; k++) begin
      idx = (rr + k) % NS;
      if (w < 0 && so[idx]) w = idx;
    end
    if (n == 0) begin
      m.valid = 1'b0;
      m.conf  = 1'b0;
    end else begin
      m.data  = words[w];
      m.sel   = SW'(w);
      m.valid = 1'b1;
      m.conf  = (n > 1);
    end
    if (ec) begin
      m.sticky = 1'b0;
      m.cnt    = 8'd0;
    end
    if (n > 1) begin
      m.sticky = 1'b1;
      if (m.cnt != 8'hff) m.cnt = m.cnt + 8'd1;
`ifdef RR_ARB_EN
      rr = (w + 1) % NS;
`endif
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("bus_out",   64'(bus_out), 64'(e.data));
    check_eq("bus_sel",   64'(bus_sel), 64'(e.sel));
    check_eq("bus_valid", 64'(bus_valid), 64'(e.valid));
    check_eq("conflict",  64'(conflict), 64'(e.conf));
    check_eq("sticky",    64'(conflict_sticky), 64'(e.sticky));
    check_eq("cnt",       64'(conflict_cnt), 64'(e.cnt));
  endtask

  function automatic logic [NS-1:0] bit_of(input int i);
    logic [NS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] pat;
    int            a;
    int            b;
    model_reset();
    // Reset held over edges with live strobes
    clr = 1'b1;
    src_out = NS'($urandom);
    src_data = {NS{32'hA5A5_5A5A}};
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    #3 clr = 1'b0;
    step(bit_of(5), 1'b0, 5, 32'hDEADBEEF);
    check_eq("first_load_word", 64'(bus_out), 64'hDEADBEEF);

    // Hold across idle cycles
    step(bit_of(16), 1'b0, 16, 32'h12345678);
    repeat (3) step('0, 1'b0, -1, '0);
    check_eq("hold_word", 64'(bus_out), 64'h12345678);

    // Two-driver conflict, then the pulse must drop
    step(bit_of(3) | bit_of(20), 1'b0, -1, '0);
    step('0, 1'b0, -1, '0);
    repeat (3) step(bit_of(3) | bit_of(20), 1'b0, -1, '0);

    // Back-to-back singles with no bubble
    for (int i = 0; i < NS; i++) step(bit_of(i), 1'b0, -1, '0);

    // Mixed random traffic
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0: pat = '0;
        1: pat = bit_of($urandom_range(0, NS-1));
        2: begin
          a = $urandom_range(0, NS-1);
          b = $urandom_range(0, NS-1);
          pat = bit_of(a) | bit_of(b);
        end
        default: pat = NS'($urandom);
      endcase
      step(pat, ($urandom_range(0, 15) == 0), -1, '0);
    end

    // Saturation, clear, and clear colliding with a conflict
    step('0, 1'b1, -1, '0);
    for (int t = 0; t < 300; t++) step(bit_of(0) | bit_of(NS-1), 1'b0, -1, '0);
    check_eq("saturated_cnt", 64'(conflict_cnt), 64'd255);
    step('0, 1'b1, -1, '0);
    check_eq("clr_only_cnt", 64'(conflict_cnt), 64'd0);
    step(bit_of(3) | bit_of(20), 1'b1, -1, '0);
    check_eq("clr_with_multi_cnt", 64'(conflict_cnt), 64'd1);

    // Asynchronous reset between edges while the bus is valid
    step(bit_of(3) | bit_of(20), 1'b0, -1, '0);
    step(bit_of(9), 1'b0, -1, '0);
    #2 clr = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("async_clr");
    #2 clr = 1'b0;
    step(bit_of(3) | bit_of(20), 1'b0, -1, '0);
    check_eq("post_clr_winner", 64'(bus_sel), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
